// File: rtl/pipeline_jump_sequencer.sv
// Redirect/drain sequencer that grants PC write and stall release to pipeline_control around taken jumps.
// Optional statistics counters are enabled by defining JUMP_SEQ_STATS_EN.
module pipeline_jump_sequencer #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        jump_start,
    input  logic        hold,
    input  logic        abort,
    output logic [1:0]  branch_status,
    output logic        fetch_flush,
    output logic        busy
`ifdef JUMP_SEQ_STATS_EN
    ,
    output logic [31:0] jump_count,
    output logic [31:0] flush_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REDIRECT = 2'b01,
        DRAIN    = 2'b10
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [3:0] drain_count;

    // Outputs are loaded together with the state they decode, so they never see jump_start directly.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            drain_count   <= 4'd0;
            branch_status <= 2'b00;
            fetch_flush   <= 1'b0;
            busy          <= 1'b0;
        end else if (abort) begin
            state         <= IDLE;
            drain_count   <= 4'd0;
            branch_status <= 2'b00;
            fetch_flush   <= 1'b0;
            busy          <= 1'b0;
        end else if (hold) begin
            if (state != IDLE && state != REDIRECT && state != DRAIN) begin
                state         <= IDLE;
                drain_count   <= 4'd0;
                branch_status <= 2'b00;
                fetch_flush   <= 1'b0;
                busy          <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (jump_start) begin
                        state         <= REDIRECT;
                        branch_status <= 2'b01;
                        fetch_flush   <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (FLUSH_CYCLES == 0) begin
                        state         <= IDLE;
                        drain_count   <= 4'd0;
                        branch_status <= 2'b00;
                        fetch_flush   <= 1'b0;
                        busy          <= 1'b0;
                    end else begin
                        state         <= DRAIN;
                        drain_count   <= DRAIN_LOAD;
                        branch_status <= 2'b10;
                        fetch_flush   <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_count == 4'd0) begin
                        state         <= IDLE;
                        branch_status <= 2'b00;
                        fetch_flush   <= 1'b0;
                        busy          <= 1'b0;
                    end else begin
                        drain_count   <= drain_count - 4'd1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    drain_count   <= 4'd0;
                    branch_status <= 2'b00;
                    fetch_flush   <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

`ifdef JUMP_SEQ_STATS_EN
    // Statistics survive abort; only reset clears them, and both wrap naturally.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            jump_count   <= 32'd0;
            flush_cycles <= 32'd0;
        end else begin
            if (!abort && !hold && state == IDLE && jump_start)
                jump_count <= jump_count + 32'd1;
            if (busy && !hold)
                flush_cycles <= flush_cycles + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
